// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with forwarding selects, load-use and branch
// handling, a multi-cycle MDU stall window, and a running stall-cycle counter.
module hazard_ctrl #(
  parameter int MDU_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic        loadE,
  input  logic        mdu_startE,
  input  logic        branch_takenE,
  input  logic [4:0]  rdM,
  input  logic        reg_writeM,
  input  logic [4:0]  rdW,
  input  logic        reg_writeW,
  output logic [1:0]  forward_op1E,
  output logic [1:0]  forward_op2E,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        mdu_doneE,
  output logic [31:0] stall_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MDU_CYCLES - 2);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic mdu_active, load_use;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (reg_writeM && rdM != 5'd0 && rdM == rs) ? 2'b10 :
           (reg_writeW && rdW != 5'd0 && rdW == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    mdu_active    = !rst && (state_q == BUSY || mdu_startE);
    mdu_doneE     = !rst && state_q == BUSY && cnt_q == 4'd0;
    state_d       = mdu_doneE ? IDLE : mdu_active ? BUSY : state_q;
    cnt_d         = (state_q == BUSY && !mdu_doneE) ? cnt_q - 4'd1 :
                    (state_q == IDLE && mdu_startE) ? CNT_INIT : cnt_q;
    // a taken branch squashes the dependent instruction, so no load-use stall is needed
    load_use      = !rst && loadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D) &&
                    !branch_takenE && !mdu_active;
    stallF        = mdu_active || load_use;
    stallD        = stallF;
    stallE        = mdu_active;
    flushM        = mdu_active;
    flushD        = !rst && branch_takenE && !mdu_active;
    flushE        = flushD || load_use;
    forward_op1E  = rst ? 2'b00 : fwd(rs1E);
    forward_op2E  = rst ? 2'b00 : fwd(rs2E);
    stall_count_d = stall_count_q + {31'd0, stallF};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven checks of hazard_ctrl plus MDU window and reset sequences.
module tb_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic loadE, mdu_startE, branch_takenE, reg_writeM, reg_writeW;
  logic [1:0] forward_op1E, forward_op2E;
  logic stallF, stallD, stallE, flushD, flushE, flushM, mdu_doneE;
  logic [31:0] stall_count;
  logic [10:0] outs;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_sc = 0;
  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic loadE, br;
    logic [4:0] rdM;
    logic wM;
    logic [4:0] rdW;
    logic wW;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[10];
  localparam logic [10:0] MDU_ON = 11'b00001110010, MDU_LAST = 11'b00001110011;
  hazard_ctrl #(.MDU_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .loadE(loadE), .mdu_startE(mdu_startE), .branch_takenE(branch_takenE),
    .rdM(rdM), .reg_writeM(reg_writeM), .rdW(rdW), .reg_writeW(reg_writeW),
    .forward_op1E(forward_op1E), .forward_op2E(forward_op2E),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .mdu_doneE(mdu_doneE), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  assign outs = {forward_op1E, forward_op2E, stallF, stallD, stallE, flushD, flushE, flushM, mdu_doneE};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_inputs();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {loadE, mdu_startE, branch_takenE, reg_writeM, reg_writeW} = '0;
  endtask
  task automatic apply(input vec_t v);
    clear_inputs();
    rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E; rdE = v.rdE;
    loadE = v.loadE; branch_takenE = v.br;
    rdM = v.rdM; reg_writeM = v.wM; rdW = v.rdW; reg_writeW = v.wW;
  endtask
  initial begin
    vecs[0] = '{0, 0, 5, 0, 0, 0, 0, 5, 1, 5, 1, 11'b10000000000};
    vecs[1] = '{0, 0, 5, 0, 0, 0, 0, 5, 0, 5, 1, 11'b01000000000};
    vecs[2] = '{0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 11'b00000000000};
    vecs[3] = '{0, 0, 3, 9, 0, 0, 0, 3, 1, 9, 1, 11'b10010000000};
    vecs[4] = '{0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 11'b00001100100};
    vecs[5] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 11'b00000000000};
    vecs[6] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 11'b00000000000};
    vecs[7] = '{7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 11'b00000001100};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 11'b00000001100};
    vecs[9] = '{7, 0, 0, 4, 7, 1, 0, 4, 1, 0, 0, 11'b00101100100};
    // reset with every hazard source active
    apply(vecs[9]);
    mdu_startE = 1'b1; branch_takenE = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_count", stall_count, 32'd0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1 chk("post_reset_idle", 32'(outs), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
      exp_sc += 32'(vecs[i].exp[6]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), stall_count, exp_sc);
    end
    // MDU window: start held for the whole window, branch and load-use attempts ignored
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      clear_inputs();
      mdu_startE = (k <= 4);
      branch_takenE = (k == 2);
      if (k == 3) begin loadE = 1'b1; rdE = 5'd7; rs1D = 5'd7; end
      #1 chk($sformatf("mdu_cyc%0d", k), 32'(outs),
             32'(k < 4 ? MDU_ON : k == 4 ? MDU_LAST : 11'b0));
      if (k <= 4) exp_sc += 1;
    end
    @(posedge clk); #1;
    chk("mdu_count", stall_count, exp_sc);
    // reset in the 2nd cycle of a new window aborts it
    @(negedge clk);
    clear_inputs();
    mdu_startE = 1'b1;
    #1 chk("abort_cyc1", 32'(outs), 32'(MDU_ON));
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_rst_outs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    chk("abort_rst_count", stall_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdu_startE = 1'b0;
    #1 chk("abort_idle", 32'(outs), 32'd0);
    @(posedge clk); #1;
    chk("abort_count_hold", stall_count, 32'd0);
    // a fresh window after the abort still lasts the full 4 cycles
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      mdu_startE = (k <= 4);
      #1 chk($sformatf("fresh_cyc%0d", k), 32'(outs),
             32'(k < 4 ? MDU_ON : k == 4 ? MDU_LAST : 11'b0));
    end
    @(posedge clk); #1;
    chk("fresh_count", stall_count, 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
